mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the pipeline's instruction-fetch port and its load/store data port.
- Accepts one transaction at a time and drives the memory for exactly one cycle.
- Waits a fixed memory read latency, then returns the response to the requester that won.
- Sits between the five-stage core's fetch and memory stages and the unified memory, which replaces the separate Instr and ReadData buses.

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and unified-memory signals shared by mem_port_arbiter and its neighbours.
// slave = arbiter side, master = core/memory side.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and load/store ports, one transaction at a time.
// Optional macro MEM_ARB_RR_EN switches tie-breaking from data-first to round-robin.
//
// state | meaning
// IDLE  | arbitrate; at most one ready per cycle
// ISSUE | drive mem_* for one cycle, load latency counter
// WAIT  | count down; capture mem_rdata when counter hits 0
// RESP  | one-cycle rvalid pulse to the owning port
module mem_port_arbiter #(
  parameter int unsigned LATENCY       = 1,
  parameter bit          RESET_PC_HOLD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        owner_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;
  logic        boot_done;
  logic        active;
  logic        i_elig;
  logic        grant_d;
  logic        grant_i;
  logic        accept;

`ifdef MEM_ARB_RR_EN
  logic        last_i_won;
`endif

  assign i_elig = bus.i_req && (boot_done || !RESET_PC_HOLD);

  always_comb begin
    grant_d = bus.d_req;
`ifdef MEM_ARB_RR_EN
    if (bus.d_req && i_elig) grant_d = last_i_won;
`endif
    grant_i = i_elig && !grant_d;
  end

  // active holds off grants until the first edge after reset release
  always_comb begin
    state_nxt     = state;
    bus.i_ready   = 1'b0;
    bus.d_ready   = 1'b0;
    bus.i_rvalid  = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    case (state)
      IDLE: begin
        if (active) begin
          bus.d_ready = grant_d;
          bus.i_ready = grant_i;
          if (grant_d || grant_i) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = wstrb_q;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        bus.i_rvalid = !owner_d;
        bus.d_rvalid = owner_d;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept      = bus.d_ready || bus.i_ready;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      boot_done <= 1'b0;
      active    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_i_won <= 1'b1;
`endif
    end else begin
      active <= 1'b1;
      state  <= state_nxt;
      if (accept) begin
        owner_d <= bus.d_ready;
        if (bus.d_ready) begin
          we_q    <= bus.d_we;
          addr_q  <= bus.d_addr;
          wdata_q <= bus.d_wdata;
          wstrb_q <= bus.d_we ? bus.d_wstrb : 4'h0;
        end else begin
          we_q    <= 1'b0;
          addr_q  <= bus.i_addr;
          wdata_q <= '0;
          wstrb_q <= 4'h0;
        end
`ifdef MEM_ARB_RR_EN
        last_i_won <= bus.i_ready;
`endif
      end
      case (state)
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == 4'd0) begin
            if (owner_d) d_rdata_q <= we_q ? 32'h0 : bus.mem_rdata;
            else         i_rdata_q <= bus.mem_rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: if (owner_d) boot_done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: LATENCY=1 instance (vector table) and LATENCY=15 boot-hold instance.
module tb_mem_port_arbiter;
  localparam int L0 = 1;
  localparam int L1 = 15;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          t_acc;
  } sb_t;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy0, busy1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   model_last_i = 1'b1;
  sb_t  sb0[$];
  sb_t  sb1[$];
  vec_t vecs [9];

  mem_port_arbiter_if bus0 ();
  mem_port_arbiter_if bus1 ();

  mem_port_arbiter #(.LATENCY(L0), .RESET_PC_HOLD(1'b0)) u0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .busy(busy0));
  mem_port_arbiter #(.LATENCY(L1), .RESET_PC_HOLD(1'b1)) u1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memory models: preset contents from init_word, stores kept in wr*/v*
  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00500293;
      32'h20:  return 32'h11223344;
      32'h104: return 32'hCAFEF00D;
      32'h200: return 32'h0BADC0DE;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  logic [31:0] wr0 [1024];
  bit          v0  [1024];
  logic [31:0] wr1 [1024];
  bit          v1  [1024];
  logic [31:0] pipe0;
  logic [31:0] pipe1 [L1];

  function automatic logic [31:0] rd0(input logic [31:0] a);
    return v0[a[11:2]] ? wr0[a[11:2]] : init_word({a[31:2], 2'b00});
  endfunction
  function automatic logic [31:0] rd1(input logic [31:0] a);
    return v1[a[11:2]] ? wr1[a[11:2]] : init_word({a[31:2], 2'b00});
  endfunction

  always @(posedge clk) begin
    if (bus0.mem_en) begin
      pipe0 <= rd0(bus0.mem_addr);
      if (bus0.mem_we) begin
        wr0[bus0.mem_addr[11:2]] <= merge(rd0(bus0.mem_addr), bus0.mem_wdata, bus0.mem_wstrb);
        v0[bus0.mem_addr[11:2]]  <= 1'b1;
      end
    end else pipe0 <= '0;
  end
  assign bus0.mem_rdata = pipe0;

  always @(posedge clk) begin
    if (bus1.mem_en) begin
      pipe1[0] <= rd1(bus1.mem_addr);
      if (bus1.mem_we) begin
        wr1[bus1.mem_addr[11:2]] <= merge(rd1(bus1.mem_addr), bus1.mem_wdata, bus1.mem_wstrb);
        v1[bus1.mem_addr[11:2]]  <= 1'b1;
      end
    end else pipe1[0] <= '0;
    for (int k = 1; k < L1; k++) pipe1[k] <= pipe1[k-1];
  end
  assign bus1.mem_rdata = pipe1[L1-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sb_size(input int n);
    return (n == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic sb_push(input int n, input sb_t e);
    if (n == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  task automatic mon(input int n, input int lat, input logic en, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd);
    sb_t e;
    if (en) begin
      if (sb_size(n) == 0) chk($sformatf("u%0d_unexpected_mem_en", n), 32'(en), 32'h0);
      else begin
        e = (n == 0) ? sb0[0] : sb1[0];
        chk($sformatf("u%0d_mem_en_cycle", n), 32'(cyc), 32'(e.t_acc + 1));
        chk($sformatf("u%0d_mem_addr", n), addr, e.addr);
        chk($sformatf("u%0d_mem_we", n), 32'(we), 32'(e.we));
        chk($sformatf("u%0d_mem_wstrb", n), 32'(wstrb), 32'(e.wstrb));
        if (e.we) chk($sformatf("u%0d_mem_wdata", n), wdata, e.wdata);
      end
    end else begin
      chk($sformatf("u%0d_mem_idle_zero", n), 32'(|{we, addr, wdata, wstrb}), 32'h0);
    end
    if (irv || drv) begin
      chk($sformatf("u%0d_rvalid_one_hot", n), 32'(irv && drv), 32'h0);
      if (sb_size(n) == 0) chk($sformatf("u%0d_unexpected_rvalid", n), 32'(irv || drv), 32'h0);
      else begin
        if (n == 0) e = sb0.pop_front(); else e = sb1.pop_front();
        chk($sformatf("u%0d_rvalid_port", n), 32'(drv), 32'(e.is_d));
        chk($sformatf("u%0d_rdata", n), e.is_d ? drd : ird, e.rdata);
        chk($sformatf("u%0d_rvalid_cycle", n), 32'(cyc), 32'(e.t_acc + lat + 2));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, L0, bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.mem_wstrb,
          bus0.i_rvalid, bus0.i_rdata, bus0.d_rvalid, bus0.d_rdata);
      mon(1, L1, bus1.mem_en, bus1.mem_we, bus1.mem_addr, bus1.mem_wdata, bus1.mem_wstrb,
          bus1.i_rvalid, bus1.i_rdata, bus1.d_rvalid, bus1.d_rdata);
    end
  end

  task automatic drain(input int n, input int budget);
    for (int c = 0; c < budget && sb_size(n) != 0; c++) begin
      @(negedge clk);
      #2;
    end
    chk($sformatf("u%0d_drain", n), 32'(sb_size(n)), 32'h0);
  endtask

  task automatic run0(input vec_t v);
    bit  i_pend, d_pend, first_done, tie, exp_d_first;
    int  t_start, t_first;
    sb_t e;
    tie = v.i_req && v.d_req;
    exp_d_first = RR_MODE ? model_last_i : 1'b1;
    first_done = 1'b0;
    t_first = 0;
    @(negedge clk);
    bus0.i_req = v.i_req;  bus0.i_addr = v.i_addr;
    bus0.d_req = v.d_req;  bus0.d_we = v.d_we;  bus0.d_addr = v.d_addr;
    bus0.d_wdata = v.d_wdata;  bus0.d_wstrb = v.d_wstrb;
    i_pend = v.i_req;  d_pend = v.d_req;
    t_start = cyc;
    for (int c = 0; c < 40 && (i_pend || d_pend); c++) begin
      #1;
      chk("u0_ready_one_hot", 32'(bus0.i_ready && bus0.d_ready), 32'h0);
      if (bus0.d_ready || bus0.i_ready) begin
        e.is_d = bus0.d_ready;
        e.t_acc = cyc;
        if (e.is_d) begin
          chk("u0_d_ready_requested", 32'(d_pend), 32'h1);
          e.we = v.d_we;  e.addr = v.d_addr;  e.wdata = v.d_wdata;
          e.wstrb = v.d_we ? v.d_wstrb : 4'h0;
          e.rdata = v.d_we ? 32'h0 : v.exp_d;
          d_pend = 1'b0;
        end else begin
          chk("u0_i_ready_requested", 32'(i_pend), 32'h1);
          e.we = 1'b0;  e.addr = v.i_addr;  e.wdata = '0;  e.wstrb = 4'h0;
          e.rdata = v.exp_i;
          i_pend = 1'b0;
        end
        if (tie && !first_done) begin
          chk("u0_tie_winner_is_d", 32'(e.is_d), 32'(exp_d_first));
          chk("u0_tie_first_accept_cycle", 32'(cyc), 32'(t_start));
        end else if (tie) begin
          chk("u0_tie_second_accept_cycle", 32'(cyc), 32'(t_first + L0 + 3));
        end
        if (!first_done) t_first = cyc;
        first_done = 1'b1;
        model_last_i = !e.is_d;
        sb_push(0, e);
      end
      @(negedge clk);
      if (!d_pend) bus0.d_req = 1'b0;
      if (!i_pend) bus0.i_req = 1'b0;
    end
    chk("u0_accept_timeout", 32'(i_pend || d_pend), 32'h0);
    bus0.i_req = 1'b0;
    bus0.d_req = 1'b0;
    drain(0, 40);
    @(negedge clk);
    #1 chk("u0_busy_low_after_resp", 32'(busy0), 32'h0);
  endtask

  task automatic xact1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp);
    sb_t e;
    bit  done;
    done = 1'b0;
    @(negedge clk);
    bus1.d_req = 1'b1;  bus1.d_we = we;  bus1.d_addr = addr;
    bus1.d_wdata = wdata;  bus1.d_wstrb = wstrb;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (bus1.d_ready) begin
        e.is_d = 1'b1;  e.we = we;  e.addr = addr;  e.wdata = wdata;
        e.wstrb = we ? wstrb : 4'h0;  e.rdata = we ? 32'h0 : exp;  e.t_acc = cyc;
        sb_push(1, e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    chk("u1_d_accept_timeout", 32'(done), 32'h1);
    bus1.d_req = 1'b0;
    drain(1, 60);
  endtask

  initial begin
    sb_t e;
    int  ta, td;
    bit  got;

    vecs[0] = '{1'b1, 32'h10,  1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h00500293, 32'h0};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        32'hDEADBEEF};
    vecs[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 32'h12345678, 4'h3, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h104, 32'h0,        4'h0, 32'h0,        32'hCAFE5678};
    vecs[5] = '{1'b1, 32'h20,  1'b1, 1'b0, 32'h100, 32'h0,        4'h0, 32'h11223344, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 32'h10,  1'b1, 1'b1, 32'h108, 32'h000000AA, 4'h1, 32'h00500293, 32'h0};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h108, 32'h0,        4'h0, 32'h0,        32'hFFFFFEAA};
    vecs[8] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h0BADC0DE, 32'h0};

    bus0.i_req = 1'b1;  bus0.i_addr = 32'h10;  bus0.d_req = 1'b1;  bus0.d_we = 1'b0;
    bus0.d_addr = 32'h0;  bus0.d_wdata = 32'h0;  bus0.d_wstrb = 4'h0;
    bus1.i_req = 1'b0;  bus1.i_addr = 32'h0;  bus1.d_req = 1'b0;  bus1.d_we = 1'b0;
    bus1.d_addr = 32'h0;  bus1.d_wdata = 32'h0;  bus1.d_wstrb = 4'h0;

    // reset state, with requests held high
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'({bus0.i_ready, bus0.d_ready}), 32'h0);
    chk("reset_busy", 32'({busy0, busy1}), 32'h0);
    chk("reset_mem_en", 32'({bus0.mem_en, bus1.mem_en}), 32'h0);
    chk("reset_rdata", bus0.i_rdata | bus0.d_rdata, 32'h0);
    bus0.i_req = 1'b0;
    bus0.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) run0(vecs[k]);

    // request raised while a fetch is in WAIT must be held off until IDLE
    @(negedge clk);
    bus0.i_req = 1'b1;  bus0.i_addr = 32'h20;
    #1 chk("held_fetch_ready", 32'(bus0.i_ready), 32'h1);
    ta = cyc;
    e.is_d = 1'b0;  e.we = 1'b0;  e.addr = 32'h20;  e.wdata = '0;  e.wstrb = 4'h0;
    e.rdata = 32'h11223344;  e.t_acc = ta;
    if (bus0.i_ready) sb_push(0, e);
    @(negedge clk);
    bus0.i_req = 1'b0;
    @(negedge clk);
    bus0.d_req = 1'b1;  bus0.d_we = 1'b0;  bus0.d_addr = 32'h10;
    #1 chk("held_no_ready_wait", 32'(bus0.d_ready), 32'h0);
    @(negedge clk);
    #1 chk("held_no_ready_resp", 32'(bus0.d_ready), 32'h0);
    @(negedge clk);
    #1 chk("held_ready_idle", 32'(bus0.d_ready), 32'h1);
    chk("held_ready_cycle", 32'(cyc), 32'(ta + L0 + 3));
    e.is_d = 1'b1;  e.addr = 32'h10;  e.rdata = 32'h00500293;  e.t_acc = cyc;
    if (bus0.d_ready) sb_push(0, e);
    model_last_i = 1'b0;
    @(negedge clk);
    bus0.d_req = 1'b0;
    drain(0, 40);

    // async reset while a fetch is in WAIT
    repeat (2) @(negedge clk);
    bus0.i_req = 1'b1;  bus0.i_addr = 32'h200;
    #1;
    e.is_d = 1'b0;  e.we = 1'b0;  e.addr = 32'h200;  e.wdata = '0;  e.wstrb = 4'h0;
    e.rdata = 32'h0BADC0DE;  e.t_acc = cyc;
    if (bus0.i_ready) sb_push(0, e);
    @(negedge clk);
    bus0.i_req = 1'b0;
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_mid_outputs", 32'(|{bus0.i_ready, bus0.d_ready, bus0.i_rvalid, bus0.d_rvalid, busy0,
        bus0.mem_en, bus0.mem_we, bus0.mem_addr, bus0.mem_wdata, bus0.mem_wstrb,
        bus0.i_rdata, bus0.d_rdata}), 32'h0);
    sb0.delete();
    model_last_i = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1 chk("rst_no_rvalid", 32'({bus0.i_rvalid, bus0.d_rvalid, busy0}), 32'h0);
    end
    run0(vecs[0]);

    // LATENCY=15 instance with boot hold: fetch blocked until the first data request completes
    @(negedge clk);
    bus1.i_req = 1'b1;  bus1.i_addr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      #1 chk("u1_pc_hold_no_iready", 32'(bus1.i_ready), 32'h0);
      @(negedge clk);
    end
    bus1.d_req = 1'b1;  bus1.d_we = 1'b1;  bus1.d_addr = 32'h300;
    bus1.d_wdata = 32'h600DF00D;  bus1.d_wstrb = 4'hF;
    #1;
    chk("u1_boot_d_ready", 32'(bus1.d_ready), 32'h1);
    chk("u1_boot_i_blocked", 32'(bus1.i_ready), 32'h0);
    td = cyc;
    e.is_d = 1'b1;  e.we = 1'b1;  e.addr = 32'h300;  e.wdata = 32'h600DF00D;  e.wstrb = 4'hF;
    e.rdata = 32'h0;  e.t_acc = td;
    if (bus1.d_ready) sb_push(1, e);
    @(negedge clk);
    bus1.d_req = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (bus1.i_ready) begin
        got = 1'b1;
        chk("u1_fetch_after_boot_cycle", 32'(cyc), 32'(td + L1 + 3));
        e.is_d = 1'b0;  e.we = 1'b0;  e.addr = 32'h10;  e.wdata = '0;  e.wstrb = 4'h0;
        e.rdata = 32'h00500293;  e.t_acc = cyc;
        sb_push(1, e);
      end
      @(negedge clk);
    end
    chk("u1_fetch_accept_timeout", 32'(got), 32'h1);
    bus1.i_req = 1'b0;
    drain(1, 60);
    xact1(1'b0, 32'h300, 32'h0, 4'h0, 32'h600DF00D);
    xact1(1'b1, 32'h304, 32'hA1B2C3D4, 4'hC, 32'h0);
    xact1(1'b0, 32'h304, 32'h0, 4'h0, 32'hA1B2FCFB);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
